sd_average_n: RTL and testbench
===============================

Name: sd_average_n

Overview:
- N-channel sigma-delta averager: combines NUM_CH 1-bit sigma-delta streams into one 1-bit sigma-delta stream whose density equals the mean input density.
- Generalises the two-input averager:
  - any channel count, including non-power-of-two;
  - per-channel mask;
  - runtime normalisation mode (fixed gain, or renormalise over active channels);
  - optional pipeline stage.
- Sits between sigma-delta sources (modulators, DSP taps) and a single sigma-delta consumer, all on one enable strobe.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..64.
- PIPE, 0, 0 = popcount and accumulate in one en cycle; 1 = registered popcount stage (one extra en cycle of latency).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  sample strobe; all state advances only when en=1
- in  input  NUM_CH  sigma-delta inputs, bit i = channel i
- mask  input  NUM_CH  1 = channel active, 0 = channel muted
- norm  input  1  0 = divide by NUM_CH (fixed gain); 1 = divide by number of active channels
- sd_out  output  1  averaged sigma-delta output, registered

Behaviour:
- Widths:
  - CW = clog2(NUM_CH+1) for counts.
  - Accumulator AW = clog2(2*NUM_CH).
  - Invariant: acc < D, where D is the current divisor.
- Config registers:
  - mask_r and norm_r load mask and norm on every en cycle.
  - The config used in a given en cycle is that cycle's mask/norm input values; there is no extra latency on config.
- Midscale toggle mid:
  - Flips every en cycle.
  - Supplies a 50% density pattern: value 0 on the first en cycle after reset, then 1, 0, ...
- Count, norm=0:
  - cnt = popcount(in & mask) + mid * popcount(~mask).
  - Muted channels contribute midscale, so gain is unchanged.
  - D = NUM_CH.
- Count, norm=1:
  - cnt = popcount(in & mask).
  - D = popcount(mask).
- Accumulate, each en cycle:
  - a = (config changed vs mask_r/norm_r) ? 0 : acc.
  - s = a + cnt.
  - If D == 0: sd_out <= mid, acc <= 0.
  - Else if s >= D: sd_out <= 1, acc <= s - D.
  - Else: sd_out <= 0, acc <= s.
  - No overflow is possible, since s <= 2D-1.
- Latency:
  - PIPE=0: in sampled at en edge k, result on sd_out after edge k.
  - PIPE=1: cnt and D are registered at edge k and accumulated at the next en edge.
  - Pipeline registers advance only on en.
- en=0: all registers hold, sd_out holds.
- Reset values:
  - acc=0, mid=0, sd_out=0, mask_r=all ones, norm_r=0, pipeline registers 0.
  - Reset overrides en.
  - Reset mid-stream restarts the pattern identically to power-up.
- Long-run density: over any window of D*k en cycles with constant inputs, ones(sd_out) = sum of input ones / D, exactly.
- Config change restarts the accumulator at 0 (see Accumulate above).
  - No glitch beyond the normal quantisation pattern.

Decomposition:
- Shared package sd_pkg:
  - clog2 function;
  - popcount function;
  - SD_MAX_CH = 64 constant.
- One sub-module, sd_popcount: NUM_CH-bit input, CW-bit count; combinational adder tree.
  - Instantiated twice: once for the active-input count, once for the mask/muted count.
- Accumulator, midscale toggle and pipeline stay in the top module.

Test Plan:
- NUM_CH=4, norm=0, mask=1111, in=1111 constant, en=1 -> sd_out=1 every cycle after first edge; in=0000 -> sd_out=0 always.
- NUM_CH=4, norm=0, mask=1111, in=0011 -> sd_out 0,1,0,1,... ; NUM_CH=3, in=001 -> 0,0,1 repeating; in=011 -> 0,1,1 repeating.
- NUM_CH=4, norm=0, mask=0001, in=0000 from reset -> exactly 24 ones in 64 en cycles (density 3/8); first four outputs 0,0,0,1.
- NUM_CH=4, norm=1, mask=0011, in=0001 -> D=2, sd_out 0,1,0,1; switch mask=0000 -> sd_out follows mid (alternating), acc=0.
- en toggled 1,0,0,1 with in=0011 -> output sequence identical to en=1 run, with holds during en=0; assert rst mid-stream -> sd_out=0 next edge, pattern restarts as after power-up.
- PIPE=1 repeat of scenario 2 -> identical sequence delayed by exactly one en cycle; random in/mask/norm vs reference model for 10k cycles -> bit-exact match.

Source files
------------

// File: rtl/sd_pkg.sv
// ============================================================================
// Module : sd_pkg
// Brief  : Shared constants and helper functions for the sigma-delta blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_pkg;

  localparam int SD_MAX_CH = 64;

  // Smallest r with 2**r >= v (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [SD_MAX_CH-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < SD_MAX_CH; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_popcount.sv
// ============================================================================
// Module : sd_popcount
// Brief  : Combinational population count built as a balanced adder tree.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_popcount
  import sd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = 3
) (
  input  logic [NUM_CH-1:0] bits_i,
  output logic [CW-1:0]     cnt_o
);

  localparam int LV = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int NP = 1 << LV;

  logic [NP-1:0] vp;
  logic [CW-1:0] t [NP];

  assign vp = NP'(bits_i);

  // In-place tree: pass l folds 2**(l+1) partial sums into 2**l.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      t[i] = CW'(vp[i]);
    end
    for (int l = LV - 1; l >= 0; l--) begin
      for (int i = 0; i < (1 << l); i++) begin
        t[i] = t[2*i] + t[2*i+1];
      end
    end
    cnt_o = t[0];
  end

endmodule

`default_nettype wire

// File: rtl/sd_average_n.sv
// ============================================================================
// Module : sd_average_n
// Brief  : N-channel sigma-delta averager with mask, normalisation and
//          optional popcount pipeline stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_average_n
  import sd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PIPE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] in,
  input  logic [NUM_CH-1:0] mask,
  input  logic              norm,
  output logic              sd_out
);

  localparam int CW = clog2(NUM_CH + 1);
  localparam int AW = clog2(2 * NUM_CH);
  localparam logic [CW-1:0] NCH_CW = CW'(NUM_CH);
  localparam logic [AW-1:0] NCH_AW = AW'(NUM_CH);

  logic [CW-1:0] act_cnt;
  logic [CW-1:0] mask_cnt;
  logic [CW-1:0] muted;

  logic [AW-1:0] cnt_c, div_c;
  logic          chg_c;

  logic [AW-1:0] cnt_s, div_s;
  logic          chg_s, mid_s;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] a, s;
  logic          sd_q, sd_d;
  logic          mid_q, mid_d;
  logic [NUM_CH-1:0] mask_q;
  logic          norm_q;

  sd_popcount #(.NUM_CH(NUM_CH), .CW(CW)) u_pc_act (
    .bits_i (in & mask),
    .cnt_o  (act_cnt)
  );

  sd_popcount #(.NUM_CH(NUM_CH), .CW(CW)) u_pc_mask (
    .bits_i (mask),
    .cnt_o  (mask_cnt)
  );

  assign muted = NCH_CW - mask_cnt;

  // Muted channels feed the midscale toggle so fixed-gain mode keeps its gain.
  always_comb begin
    cnt_c = AW'(act_cnt);
    div_c = NCH_AW;
    if (norm) begin
      div_c = AW'(mask_cnt);
    end else if (mid_q) begin
      cnt_c = AW'(act_cnt) + AW'(muted);
    end
  end

  assign chg_c = (mask != mask_q) || (norm != norm_q);

  generate
    if (PIPE != 0) begin : g_pipe
      logic [AW-1:0] cnt_p_q, div_p_q;
      logic          chg_p_q, mid_p_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_p_q <= '0;
          div_p_q <= '0;
          chg_p_q <= 1'b0;
          mid_p_q <= 1'b0;
        end else if (en) begin
          cnt_p_q <= cnt_c;
          div_p_q <= div_c;
          chg_p_q <= chg_c;
          mid_p_q <= mid_q;
        end
      end

      assign cnt_s = cnt_p_q;
      assign div_s = div_p_q;
      assign chg_s = chg_p_q;
      assign mid_s = mid_p_q;
    end else begin : g_nopipe
      assign cnt_s = cnt_c;
      assign div_s = div_c;
      assign chg_s = chg_c;
      assign mid_s = mid_q;
    end
  endgenerate

  // s never exceeds 2*D-1, so AW bits always hold it.
  always_comb begin
    a     = chg_s ? '0 : acc_q;
    s     = a + cnt_s;
    mid_d = ~mid_q;
    if (div_s == '0) begin
      sd_d  = mid_s;
      acc_d = '0;
    end else if (s >= div_s) begin
      sd_d  = 1'b1;
      acc_d = s - div_s;
    end else begin
      sd_d  = 1'b0;
      acc_d = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sd_q   <= 1'b0;
      mid_q  <= 1'b0;
      mask_q <= '1;
      norm_q <= 1'b0;
    end else if (en) begin
      acc_q  <= acc_d;
      sd_q   <= sd_d;
      mid_q  <= mid_d;
      mask_q <= mask;
      norm_q <= norm;
    end
  end

  assign sd_out = sd_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_average_n.sv
// ============================================================================
// Module : tb_sd_average_n
// Brief  : Self-checking bench for sd_average_n (N=4, N=3, N=5, N=4 piped).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_average_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       norm = 1'b0;
  logic [4:0] in_v = '0;
  logic [4:0] mask_v = '1;
  logic       sd4, sd3, sd5, sd4p;
  logic [3:0] outs;

  always #5 clk = ~clk;

  sd_average_n #(.NUM_CH(4), .PIPE(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .in(in_v[3:0]), .mask(mask_v[3:0]),
    .norm(norm), .sd_out(sd4));
  sd_average_n #(.NUM_CH(3), .PIPE(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .in(in_v[2:0]), .mask(mask_v[2:0]),
    .norm(norm), .sd_out(sd3));
  sd_average_n #(.NUM_CH(5), .PIPE(0)) u5 (
    .clk(clk), .rst(rst), .en(en), .in(in_v), .mask(mask_v),
    .norm(norm), .sd_out(sd5));
  sd_average_n #(.NUM_CH(4), .PIPE(1)) u4p (
    .clk(clk), .rst(rst), .en(en), .in(in_v[3:0]), .mask(mask_v[3:0]),
    .norm(norm), .sd_out(sd4p));

  assign outs = {sd4p, sd5, sd3, sd4};

  int total = 0;
  int bad   = 0;

  logic [3:0] sbq[$];
  int         m_acc[3];
  bit         m_mid[3];
  logic [4:0] m_mr[3];
  bit         m_nr[3];
  bit         m_out[3];
  bit         p_out;

  // Reference behaviour of one unpiped averager of n channels.
  task automatic mdl(input int id, input int n);
    logic [4:0] all, mv;
    int ones, act, cnt, d, a, s;
    bit chg;
    all  = 5'((1 << n) - 1);
    mv   = mask_v & all;
    ones = 0;
    act  = 0;
    if (rst) begin
      m_acc[id] = 0; m_mid[id] = 0; m_out[id] = 0; m_mr[id] = all; m_nr[id] = 0;
    end else if (en) begin
      for (int i = 0; i < n; i++) begin
        if (mv[i]) begin
          act++;
          if (in_v[i]) ones++;
        end
      end
      if (norm) begin
        cnt = ones; d = act;
      end else begin
        cnt = ones + (m_mid[id] ? (n - act) : 0); d = n;
      end
      chg = (mv != m_mr[id]) || (norm != m_nr[id]);
      a = chg ? 0 : m_acc[id];
      s = a + cnt;
      if (d == 0) begin
        m_out[id] = m_mid[id]; m_acc[id] = 0;
      end else if (s >= d) begin
        m_out[id] = 1; m_acc[id] = s - d;
      end else begin
        m_out[id] = 0; m_acc[id] = s;
      end
      m_mr[id]  = mv;
      m_nr[id]  = norm;
      m_mid[id] = !m_mid[id];
    end
  endtask

  // Drive one clock of stimulus and push the expected outputs.
  task automatic step(input bit r, input bit e, input logic [4:0] iv,
                      input logic [4:0] mv, input bit nv);
    @(negedge clk);
    rst = r; en = e; in_v = iv; mask_v = mv; norm = nv;
    if (r) p_out = 0;
    else if (e) p_out = m_out[0];
    mdl(0, 4); mdl(1, 3); mdl(2, 5);
    sbq.push_back({p_out, m_out[2], m_out[1], m_out[0]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 5'h1f, 5'h1f, 0);
      exp = sbq.pop_front();
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL reset_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      total++;
      if (outs !== 4'b0000) begin
        bad++; $display("FAIL reset_zero k=%0d got=%b want=0000", k, outs);
      end
    end
  endtask

  task automatic test_full_scale();
    logic [3:0] exp;
    step(1, 1, 0, 5'h1f, 0);
    void'(sbq.pop_front());
    for (int k = 0; k < 16; k++) begin
      step(0, 1, (k < 8) ? 5'h1f : 5'h00, 5'h1f, 0);
      exp = sbq.pop_front();
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL full_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      total++;
      if (outs[2:0] !== ((k < 8) ? 3'b111 : 3'b000)) begin
        bad++; $display("FAIL full_const k=%0d got=%b want=%b", k, outs[2:0],
                        (k < 8) ? 3'b111 : 3'b000);
      end
    end
  endtask

  task automatic test_half_and_pipe();
    logic [3:0] exp;
    logic [2:0] want;
    step(1, 1, 0, 5'h1f, 0);
    void'(sbq.pop_front());
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 5'b00011, 5'h1f, 0);
      exp = sbq.pop_front();
      want = {(k == 0) ? 1'b0 : 1'((k - 1) % 2), 1'((k % 3) != 0), 1'(k % 2)};
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL half_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      total++;
      if ({outs[3], outs[1:0]} !== want) begin
        bad++; $display("FAIL half_const k=%0d got=%b want=%b", k,
                        {outs[3], outs[1:0]}, want);
      end
    end
    step(1, 1, 0, 5'h1f, 0);
    void'(sbq.pop_front());
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 5'b00001, 5'h1f, 0);
      exp = sbq.pop_front();
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL third_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      total++;
      if (sd3 !== ((k % 3) == 2)) begin
        bad++; $display("FAIL third_const k=%0d got=%b want=%b", k, sd3, (k % 3) == 2);
      end
    end
  endtask

  task automatic test_density();
    logic [3:0] exp;
    int ones;
    ones = 0;
    step(1, 1, 0, 5'h1f, 0);
    void'(sbq.pop_front());
    for (int k = 0; k < 64; k++) begin
      step(0, 1, 5'b00000, 5'b00001, 0);
      exp = sbq.pop_front();
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL dens_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      if (k < 4) begin
        total++;
        if (sd4 !== (k == 3)) begin
          bad++; $display("FAIL dens_first k=%0d got=%b want=%b", k, sd4, k == 3);
        end
      end
      if (sd4 === 1'b1) ones++;
    end
    total++;
    if (ones != 24) begin
      bad++; $display("FAIL dens_count got=%0d want=24", ones);
    end
  endtask

  task automatic test_norm();
    logic [3:0] exp;
    step(1, 1, 0, 5'h1f, 0);
    void'(sbq.pop_front());
    for (int j = 0; j < 12; j++) begin
      step(0, 1, 5'b00001, (j < 6) ? 5'b00011 : 5'b00000, 1);
      exp = sbq.pop_front();
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL norm_sb j=%0d got=%b want=%b", j, outs, exp);
      end
      total++;
      if (sd4 !== 1'(j % 2)) begin
        bad++; $display("FAIL norm_const j=%0d got=%b want=%b", j, sd4, 1'(j % 2));
      end
    end
  endtask

  task automatic test_en_gating();
    logic [3:0] exp;
    bit ens[10] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1};
    int ne;
    bit want;
    ne = 0;
    want = 0;
    step(1, 1, 0, 5'h1f, 0);
    void'(sbq.pop_front());
    for (int k = 0; k < 10; k++) begin
      step(0, ens[k], 5'b00011, 5'h1f, 0);
      exp = sbq.pop_front();
      if (ens[k]) begin
        want = 1'(ne % 2);
        ne++;
      end
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL gate_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      total++;
      if (sd4 !== want) begin
        bad++; $display("FAIL gate_const k=%0d got=%b want=%b", k, sd4, want);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 1, 5'b00011, 5'h1f, 0);
      exp = sbq.pop_front();
      want = (k == 0) ? 1'b0 : 1'((k - 1) % 2);
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL rst_mid_sb k=%0d got=%b want=%b", k, outs, exp);
      end
      total++;
      if (sd4 !== want) begin
        bad++; $display("FAIL rst_mid_const k=%0d got=%b want=%b", k, sd4, want);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    logic [4:0] mv;
    bit nv;
    mv = 5'h1f;
    nv = 0;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(15) == 0) mv = 5'($urandom);
      if ($urandom_range(31) == 0) nv = !nv;
      step($urandom_range(499) == 0, $urandom_range(3) != 0, 5'($urandom), mv, nv);
      exp = sbq.pop_front();
      total++;
      if (outs !== exp) begin
        bad++; $display("FAIL random k=%0d got=%b want=%b", k, outs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_half_and_pipe();
    test_density();
    test_norm();
    test_en_gating();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
